lifo_fifo_ctrl: RTL

Pointer and state controller that sits directly upstream of the 4-entry, 1-bit LIFO/FIFO storage stage. It accepts push (`write`) and pop (`del`) requests plus a LIFO/FIFO mode select. It drives the storage stage's write enable, write address and read address, and tracks occupancy. It flags overflow, underflow and illegal mode changes by entering a sticky error state, which is left only through a synchronous clear.

---
 rtl/lifo_fifo_pkg.sv | 17 +
 rtl/lifo_fifo_ctrl_wrap_counter.sv | 31 +++
 rtl/lifo_fifo_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lifo_fifo_pkg.sv
// Shared types and defaults for the LIFO/FIFO pointer controller.
package lifo_fifo_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 2;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_LIFO = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2,
        ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/lifo_fifo_ctrl_wrap_counter.sv
// Modulo-2^AW up/down counter used for the storage pointers.
module wrap_counter
    import lifo_fifo_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [AW-1:0] o_q
);

    logic [AW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && !i_dec) begin
            r_q <= r_q + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_q <= r_q - 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/lifo_fifo_ctrl.sv
// Pointer/occupancy controller for a small LIFO/FIFO storage stage,
// with a sticky error state left only through clr.
module lifo_fifo_ctrl
    import lifo_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          l_f,
    input  logic          write,
    input  logic          del,
    input  logic          clr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          error,
    output logic [1:0]    state
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nx;
    logic          r_mode;
    state_e        r_state;

    logic w_live;
    logic w_empty;
    logic w_full;
    logic w_lifo;
    logic w_mode_err;
    logic w_under;
    logic w_over;
    logic w_acc;
    logic w_push;
    logic w_pop;
    logic w_both;

    // rst_n gates the request path so outputs settle during reset
    assign w_live     = rst_n && !clr && (r_state != ERR);
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_lifo     = (r_mode == MODE_LIFO);
    assign w_mode_err = !w_empty && (l_f != r_mode);
    assign w_under    = del && w_empty;
    assign w_over     = write && !del && w_full;
    assign w_acc      = w_live && !(w_mode_err || w_under || w_over);
    assign w_push     = w_acc && write && !del;
    assign w_pop      = w_acc && del && !write;
    assign w_both     = w_acc && write && del;

    assign wr_en   = w_push || w_both;
    assign wr_addr = (w_both && w_lifo) ? w_wr_ptr - 1'b1 : w_wr_ptr;
    assign rd_addr = w_lifo ? w_wr_ptr - 1'b1 : w_rd_ptr;

    wrap_counter #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (clr),
        .i_inc (w_push || (w_both && !w_lifo)),
        .i_dec (w_pop && w_lifo),
        .o_q   (w_wr_ptr)
    );

    wrap_counter #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (clr || ((r_state != ERR) && w_lifo)),
        .i_inc ((w_pop || w_both) && !w_lifo),
        .i_dec (1'b0),
        .o_q   (w_rd_ptr)
    );

    always_comb begin
        w_cnt_nx = r_cnt;
        if (w_push) begin
            w_cnt_nx = r_cnt + 1'b1;
        end else if (w_pop) begin
            w_cnt_nx = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mode  <= MODE_FIFO;
            r_state <= EMPTY;
        end else if (clr) begin
            r_cnt   <= '0;
            r_mode  <= l_f;
            r_state <= EMPTY;
        end else if (r_state != ERR) begin
            if (w_empty) begin
                r_mode <= l_f;
            end
            if (!w_acc) begin
                r_state <= ERR;
            end else begin
                r_cnt <= w_cnt_nx;
                if (w_cnt_nx == '0) begin
                    r_state <= EMPTY;
                end else if (w_cnt_nx == CNT_FULL) begin
                    r_state <= FULL;
                end else begin
                    r_state <= PART;
                end
            end
        end
    end

    assign count = r_cnt;
    assign empty = w_empty;
    assign full  = w_full;
    assign error = (r_state == ERR);
    assign state = r_state;

endmodule
